// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the single register-file write port between the ALU
//               writeback and a long-latency unit, and keeps a busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_wb_valid,
    input  logic [4:0]      alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_stall,
    input  logic            ll_issue,
    input  logic [4:0]      ll_issue_rd,
    input  logic            ll_wb_valid,
    output logic            ll_wb_ready,
    input  logic [4:0]      ll_wb_rd,
    input  logic [XLEN-1:0] ll_wb_data,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    output logic [31:0]     busy_vec,
    output logic            err_waw,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int                CNT_W        = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  c_starve_max = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             r_alu_stall;
    logic [31:0]      r_busy;
    logic [31:0]      w_busy_nxt;
    logic             r_err_waw;
    logic             w_alu_go;
    logic             w_ll_acc;
    logic             w_ll_denied;
    logic             w_waw_issue;
    logic             w_waw_alu;

    // ALU has priority unless the LL unit has been starved long enough.
    assign w_alu_go    = alu_wb_valid & ~r_alu_stall;
    assign ll_wb_ready = ~w_alu_go;
    assign w_ll_acc    = ll_wb_valid & ll_wb_ready;
    assign w_ll_denied = ll_wb_valid & ~ll_wb_ready;

    always_comb begin
        rf_rd    = 5'd0;
        rf_wdata = '0;
        if (w_alu_go) begin
            rf_rd    = alu_wb_rd;
            rf_wdata = alu_wb_data;
        end else if (ll_wb_valid) begin
            rf_rd    = ll_wb_rd;
            rf_wdata = ll_wb_data;
        end
    end

    // Transfers to x0 still complete their handshake but never write.
    assign rf_we = rst_n & (w_alu_go | w_ll_acc) & (rf_rd != 5'd0);

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_ll_acc)
            w_starve_nxt = '0;
        else if (w_ll_denied && (r_starve_cnt != c_starve_max))
            w_starve_nxt = r_starve_cnt + 1'b1;
    end

    // Clear before set so a same-cycle reissue of the retiring register stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_ll_acc)
            w_busy_nxt[ll_wb_rd] = 1'b0;
        if (ll_issue && (ll_issue_rd != 5'd0))
            w_busy_nxt[ll_issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    assign w_waw_issue = ll_issue && (ll_issue_rd != 5'd0) && r_busy[ll_issue_rd]
                         && !(w_ll_acc && (ll_wb_rd == ll_issue_rd));
    assign w_waw_alu   = w_alu_go && (alu_wb_rd != 5'd0) && r_busy[alu_wb_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_alu_stall  <= 1'b0;
            r_busy       <= '0;
            r_err_waw    <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_alu_stall  <= (w_starve_nxt == c_starve_max);
            r_busy       <= w_busy_nxt;
            r_err_waw    <= r_err_waw | w_waw_issue | w_waw_alu;
        end
    end

    assign alu_stall = r_alu_stall;
    assign busy_vec  = r_busy;
    assign err_waw   = r_err_waw;
    assign hazard    = r_busy[chk_rs1] | r_busy[chk_rs2] | r_busy[chk_rd];

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Directed self-checking bench for rf_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_wb_valid;
    logic [4:0]      alu_wb_rd;
    logic [XLEN-1:0] alu_wb_data;
    logic            alu_stall;
    logic            ll_issue;
    logic [4:0]      ll_issue_rd;
    logic            ll_wb_valid;
    logic            ll_wb_ready;
    logic [4:0]      ll_wb_rd;
    logic [XLEN-1:0] ll_wb_data;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic [4:0]      chk_rd;
    logic            hazard;
    logic [31:0]     busy_vec;
    logic            err_waw;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .alu_stall(alu_stall),
        .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
        .ll_wb_valid(ll_wb_valid), .ll_wb_ready(ll_wb_ready),
        .ll_wb_rd(ll_wb_rd), .ll_wb_data(ll_wb_data),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .busy_vec(busy_vec), .err_waw(err_waw),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = '0;
        ll_issue = 1'b0; ll_issue_rd = 5'd0;
        ll_wb_valid = 1'b0; ll_wb_rd = 5'd0; ll_wb_data = '0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (busy_vec !== 32'h0 || alu_stall !== 1'b0 || err_waw !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: busy=%h stall=%b err=%b, want 0/0/0", busy_vec, alu_stall, err_waw);
        end
        // Build up busy[5] and a stalled ALU, then reset mid-traffic.
        ll_issue = 1'b1; ll_issue_rd = 5'd5;
        tick();
        ll_issue = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'h1111;
        ll_wb_valid = 1'b1; ll_wb_rd = 5'd9; ll_wb_data = 32'h9999;
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (alu_stall !== 1'b1 || busy_vec[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: stall=%b busy5=%b, want 1/1", alu_stall, busy_vec[5]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy_vec !== 32'h0 || alu_stall !== 1'b0 || err_waw !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%h stall=%b err=%b we=%b, want 0/0/0/0",
                     busy_vec, alu_stall, err_waw, rf_we);
        end
        tick();
        n_tests++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_we_held: rf_we=%b, want 0", rf_we);
        end
        do_reset();
    endtask

    task automatic test_alu_only();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF || ll_wb_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_only: we=%b rd=%0d data=%h ready=%b, want 1/5/deadbeef/0",
                     rf_we, rf_rd, rf_wdata, ll_wb_ready);
        end
        tick();
        idle();
    endtask

    task automatic test_rd_zero();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h1234;
        #1;
        n_tests++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_rd0: rf_we=%b, want 0", rf_we);
        end
        tick();
        idle();
        ll_wb_valid = 1'b1; ll_wb_rd = 5'd0; ll_wb_data = 32'h5678;
        #1;
        n_tests++;
        if (rf_we !== 1'b0 || ll_wb_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ll_rd0: we=%b ready=%b, want 0/1", rf_we, ll_wb_ready);
        end
        tick();
        idle();
    endtask

    task automatic test_conflict();
        ll_issue = 1'b1; ll_issue_rd = 5'd7;
        tick();
        ll_issue = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h0000_0033;
        ll_wb_valid = 1'b1; ll_wb_rd = 5'd7; ll_wb_data = 32'h0000_0077;
        #1;
        n_tests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h33 || ll_wb_ready !== 1'b0
            || busy_vec[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_alu: we=%b rd=%0d data=%h ready=%b busy7=%b, want 1/3/33/0/1",
                     rf_we, rf_rd, rf_wdata, ll_wb_ready, busy_vec[7]);
        end
        tick();
        alu_wb_valid = 1'b0;
        #1;
        n_tests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h77 || ll_wb_ready !== 1'b1
            || busy_vec[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_ll: we=%b rd=%0d data=%h ready=%b busy7=%b, want 1/7/77/1/1",
                     rf_we, rf_rd, rf_wdata, ll_wb_ready, busy_vec[7]);
        end
        tick();
        idle();
        n_tests++;
        if (busy_vec[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_clear: busy7=%b, want 0", busy_vec[7]);
        end
    endtask

    task automatic test_starve();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd2; alu_wb_data = 32'hAAAA_0002;
        ll_wb_valid = 1'b1; ll_wb_rd = 5'd4; ll_wb_data = 32'hBBBB_0004;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (alu_stall !== 1'b0 || ll_wb_ready !== 1'b0 || rf_rd !== 5'd2) begin
                n_fail++;
                $display("FAIL starve_deny%0d: stall=%b ready=%b rd=%0d, want 0/0/2",
                         i, alu_stall, ll_wb_ready, rf_rd);
            end
            tick();
        end
        n_tests++;
        if (alu_stall !== 1'b1 || ll_wb_ready !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd4
            || rf_wdata !== 32'hBBBB_0004) begin
            n_fail++;
            $display("FAIL starve_grant: stall=%b ready=%b we=%b rd=%0d data=%h, want 1/1/1/4/bbbb0004",
                     alu_stall, ll_wb_ready, rf_we, rf_rd, rf_wdata);
        end
        tick();
        ll_wb_valid = 1'b0;
        #1;
        n_tests++;
        if (alu_stall !== 1'b0 || rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'hAAAA_0002) begin
            n_fail++;
            $display("FAIL starve_release: stall=%b we=%b rd=%0d data=%h, want 0/1/2/aaaa0002",
                     alu_stall, rf_we, rf_rd, rf_wdata);
        end
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        ll_issue = 1'b1; ll_issue_rd = 5'd10;
        tick();
        ll_issue = 1'b0;
        chk_rs1 = 5'd10;
        #1;
        n_tests++;
        if (busy_vec[10] !== 1'b1 || hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set: busy10=%b hazard=%b, want 1/1", busy_vec[10], hazard);
        end
        chk_rs1 = 5'd11;
        #1;
        n_tests++;
        if (hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_nohaz: hazard=%b, want 0", hazard);
        end
        chk_rd = 5'd10;
        #1;
        n_tests++;
        if (hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_rd_haz: hazard=%b, want 1", hazard);
        end
        chk_rd = 5'd0;
        ll_issue = 1'b1; ll_issue_rd = 5'd0;
        tick();
        n_tests++;
        if (busy_vec !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL sb_rd0: busy=%h, want 00000400", busy_vec);
        end
        ll_issue_rd = 5'd12; chk_rs2 = 5'd12;
        #1;
        n_tests++;
        if (hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_nobypass: hazard=%b, want 0", hazard);
        end
        tick();
        ll_issue = 1'b0;
        #1;
        n_tests++;
        if (hazard !== 1'b1 || busy_vec !== 32'h0000_1400) begin
            n_fail++;
            $display("FAIL sb_set12: hazard=%b busy=%h, want 1/00001400", hazard, busy_vec);
        end
        chk_rs2 = 5'd0;
        ll_issue = 1'b1; ll_issue_rd = 5'd10;
        ll_wb_valid = 1'b1; ll_wb_rd = 5'd10; ll_wb_data = 32'h0000_00AA;
        #1;
        n_tests++;
        if (ll_wb_ready !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd10) begin
            n_fail++;
            $display("FAIL sb_same_acc: ready=%b we=%b rd=%0d, want 1/1/10", ll_wb_ready, rf_we, rf_rd);
        end
        tick();
        idle();
        n_tests++;
        if (busy_vec[10] !== 1'b1 || err_waw !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_set_wins: busy10=%b err=%b, want 1/0", busy_vec[10], err_waw);
        end
    endtask

    task automatic test_waw();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd10; alu_wb_data = 32'h0000_0010;
        #1;
        n_tests++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd10 || err_waw !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_alu_write: we=%b rd=%0d err=%b, want 1/10/0", rf_we, rf_rd, err_waw);
        end
        tick();
        idle();
        tick();
        tick();
        n_tests++;
        if (err_waw !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_alu_sticky: err=%b, want 1", err_waw);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (err_waw !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_reset: err=%b, want 0", err_waw);
        end
        do_reset();
        ll_issue = 1'b1; ll_issue_rd = 5'd6;
        tick();
        tick();
        ll_issue = 1'b0;
        n_tests++;
        if (err_waw !== 1'b1 || busy_vec !== 32'h0000_0040) begin
            n_fail++;
            $display("FAIL waw_issue: err=%b busy=%h, want 1/00000040", err_waw, busy_vec);
        end
        do_reset();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_alu_only();
        test_rd_zero();
        test_conflict();
        test_starve();
        test_scoreboard();
        test_waw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
